// File: rtl/joy_db9md_scan.sv
// Mega Drive DB9 pad scanner: sweeps NPORTS pads over one pin bus and publishes a 12-bit word per port.
// Each port's word, connected and six_btn are written together at the end of its phase 7; there is no backpressure.
module joy_db9md_scan #(
  parameter int NPORTS    = 2,
  parameter int PHASE_CYC = 384,
  parameter int IDLE_CYC  = 96000,
  parameter int PW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5:0]             joy_in,
  output logic                   joy_sel,
  output logic [PW-1:0]          joy_port,
  output logic [12*NPORTS-1:0]   joystick,
  output logic [NPORTS-1:0]      connected,
  output logic [NPORTS-1:0]      six_btn,
  output logic                   scan_done
);

  localparam int CMAX = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int CW   = $clog2(CMAX);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [5:0]    sync1, sync2;
  logic [5:0]    s;
  logic [CW-1:0] cnt;
  logic [2:0]    phase;
  logic [11:0]   shadow;
  logic          present;
  logic          six;
  logic          phase_end;
  logic          last_port;

  // Idle pins float high, so the synchroniser resets to the released level.
  assign s         = ~sync2;
  assign phase_end = (cnt == CW'(PHASE_CYC - 1));
  assign last_port = (joy_port == PW'(NPORTS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 6'h3f;
      sync2 <= 6'h3f;
    end else begin
      sync1 <= joy_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      phase     <= '0;
      shadow    <= '0;
      present   <= 1'b0;
      six       <= 1'b0;
      joy_sel   <= 1'b1;
      joy_port  <= '0;
      joystick  <= '0;
      connected <= '0;
      six_btn   <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          joy_sel  <= 1'b1;
          joy_port <= '0;
          if (cnt == CW'(IDLE_CYC - 1)) begin
            cnt   <= '0;
            phase <= '0;
            state <= SCAN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SCAN: begin
          if (!phase_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt   <= '0;
            phase <= phase + 1'b1;
            // Select for phase p+1 is ~(p+1)[0], which equals p[0].
            joy_sel <= phase[0];
            case (phase)
              3'd0: shadow[5:0] <= {s[5], s[4], s[0], s[1], s[2], s[3]};
              3'd1: begin
                shadow[6] <= s[4];
                shadow[7] <= s[5];
                present   <= &s[3:2];
              end
              3'd5: six <= &s[3:0];
              3'd6: shadow[11:8] <= six ? {s[0], s[1], s[2], s[3]} : 4'h0;
              3'd7: begin
                joystick[int'(joy_port)*12 +: 12] <= present ? shadow : 12'h000;
                connected[joy_port]               <= present;
                six_btn[joy_port]                 <= present & six;
                joy_sel                           <= 1'b1;
                if (last_port) begin
                  joy_port  <= '0;
                  scan_done <= 1'b1;
                  state     <= IDLE;
                end else begin
                  joy_port <= joy_port + 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_joy_db9md_scan.sv
// Bench for joy_db9md_scan: behavioural pads on four ports, expected words derived from pad type and pressed buttons.
module tb_joy_db9md_scan;

  localparam int NP    = 4;
  localparam int PH    = 6;
  localparam int ID    = 150;
  localparam int PW    = 2;
  localparam int SWEEP = ID + NP * 8 * PH;
  localparam int LIMIT = 3 * SWEEP;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [5:0]          joy_in;
  logic                joy_sel;
  logic [PW-1:0]       joy_port;
  logic [12*NP-1:0]    joystick;
  logic [NP-1:0]       connected;
  logic [NP-1:0]       six_btn;
  logic                scan_done;

  int vectors = 0;
  int miscompares = 0;

  // Pad types: 0 = absent (floating, with noise on non-L/R pins), 1 = 3-button, 2 = 6-button.
  int          ptype [NP];
  logic [11:0] pbtn  [NP];
  int          lcount[NP];
  logic [5:0]  noise = '0;
  logic [PW-1:0] prev_port = '0;
  logic        prev_sel = 1'b1;

  joy_db9md_scan #(.NPORTS(NP), .PHASE_CYC(PH), .IDLE_CYC(ID), .PW(PW)) dut (
    .clk(clk), .reset_n(reset_n), .joy_in(joy_in), .joy_sel(joy_sel), .joy_port(joy_port),
    .joystick(joystick), .connected(connected), .six_btn(six_btn), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Pressed-pin view of a pad (1 = pin pulled low); m = select falling edges since its port was routed.
  function automatic logic [5:0] pad_act(input int t, input logic [11:0] b, input logic sel,
                                         input int m, input logic [5:0] nz);
    if (t == 0) return nz & 6'b110011;
    if (sel) begin
      if (t == 2 && m == 3) return {b[5], b[4], b[8], b[9], b[10], b[11]};
      return {b[5], b[4], b[0], b[1], b[2], b[3]};
    end
    if (t == 2 && m == 3) return {b[7], b[6], 4'b1111};
    return {b[7], b[6], 2'b11, b[2], b[3]};
  endfunction

  assign joy_in = ~pad_act(ptype[joy_port], pbtn[joy_port], joy_sel, lcount[joy_port], noise);

  always @(negedge clk) begin
    noise = 6'($urandom);
    if (joy_port != prev_port) lcount[joy_port] = 0;
    else if (prev_sel && !joy_sel) lcount[joy_port] = lcount[joy_port] + 1;
    prev_port = joy_port;
    prev_sel  = joy_sel;
  end

  function automatic logic [11:0] exp_word(input int t, input logic [11:0] b);
    if (t == 0) return 12'h000;
    if (t == 1) return b & 12'h0ff;
    return b;
  endfunction

  function automatic logic [11:0] rand_btn();
    logic [11:0] b;
    b = 12'($urandom);
    if (b[3]) b[2] = 1'b0;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("word%0d", p), 32'(joystick[p*12 +: 12]), 32'(exp_word(ptype[p], pbtn[p])));
      chk($sformatf("conn%0d", p), 32'(connected[p]), 32'(ptype[p] != 0));
      chk($sformatf("six%0d", p), 32'(six_btn[p]), 32'(ptype[p] == 2));
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < LIMIT);
    if (!scan_done) chk("scan_done_timeout", 32'(n), 32'(SWEEP));
  endtask

  task automatic wait_port(input logic [PW-1:0] p);
    int n = 0;
    while (joy_port != p && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (joy_port != p) chk("port_timeout", 32'(joy_port), 32'(p));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_joystick"}, 32'(joystick == '0), 32'd1);
    chk({tag, "_connected"}, 32'(connected), 32'd0);
    chk({tag, "_six"}, 32'(six_btn), 32'd0);
    chk({tag, "_sel"}, 32'(joy_sel), 32'd1);
    chk({tag, "_port"}, 32'(joy_port), 32'd0);
    chk({tag, "_done"}, 32'(scan_done), 32'd0);
  endtask

  initial begin
    int n, total;
    logic [PW-1:0] seq[$];
    logic [11:0] old_w;

    for (int p = 0; p < NP; p++) begin
      ptype[p] = 0; pbtn[p] = '0; lcount[p] = 0;
    end
    reset_n = 1'b0;
    repeat (20) @(negedge clk);
    check_reset_outputs("rst");

    // Port 0: 3-button A+Up; port 1: 6-button Z+Mode+Right; port 2 absent; port 3 random 6-button.
    ptype[0] = 1; pbtn[0] = 12'h048;
    ptype[1] = 2; pbtn[1] = 12'h901;
    ptype[2] = 0; pbtn[2] = 12'hfff;
    ptype[3] = 2; pbtn[3] = rand_btn();
    reset_n = 1'b1;
    seq.push_back(joy_port);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (joy_port != seq[$]) seq.push_back(joy_port);
    end while (!scan_done && n < LIMIT);
    chk("first_done_in_window", 32'(n >= SWEEP - 2 && n <= SWEEP + 2), 32'd1);
    chk("port_seq_len", 32'(seq.size()), 32'd5);
    for (int i = 0; i < 5 && i < seq.size(); i++)
      chk($sformatf("port_seq%0d", i), 32'(seq[i]), 32'(i % NP));
    chk("p0_a_up", 32'(joystick[11:0]), 32'h048);
    chk("p1_z_mode_r", 32'(joystick[23:12]), 32'h901);
    check_all();

    // Randomised sweeps; pads only change while the scanner idles.
    for (int k = 0; k < 10; k++) begin
      for (int p = 0; p < NP; p++) begin
        ptype[p] = int'($urandom_range(0, 2));
        pbtn[p]  = rand_btn();
      end
      wait_done(n);
      chk("sweep_len", 32'(n), 32'(SWEEP));
      check_all();
    end

    // Port 0 releases A after its own publish: old word stays until the next sweep.
    ptype[0] = 1; pbtn[0] = 12'h048;
    wait_done(n);
    check_all();
    old_w = exp_word(ptype[0], pbtn[0]);
    wait_done(n);
    wait_port(2'd1);
    pbtn[0] = 12'h008;
    repeat (PH * 3) @(negedge clk);
    chk("hold_mid_sweep", 32'(joystick[11:0]), 32'(old_w));
    wait_done(n);
    chk("hold_at_done", 32'(joystick[11:0]), 32'(old_w));
    wait_done(n);
    chk("release_seen", 32'(joystick[11:0]), 32'h008);
    check_all();

    // Reset during phase 4 of port 1.
    wait_port(2'd1);
    repeat (4 * PH + 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (ID - 5) @(negedge clk);
    chk("no_early_publish", 32'(joystick == '0 && connected == '0), 32'd1);
    wait_done(n);
    total = ID - 5 + n;
    chk("post_reset_sweep", 32'(total), 32'(SWEEP));
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_db9md_scan.md
Name: joy_db9md_scan

Overview:
- Parametrised successor to the two-port DB9 Mega Drive pad reader used on the SNAC user port.
- Time-multiplexes NPORTS pads over one shared 6-pin input bus and drives the select line through the full 8-phase Mega Drive protocol.
- Detects per port whether a pad is present and whether it is a 6-button pad.
- Publishes one active-high 12-bit button word per port to the core's input-mapping logic.

Parameters:
- NPORTS, 2, number of multiplexed pad ports (1..4).
- PHASE_CYC, 384, clk cycles per select phase (8 us at 48 MHz); must be >= 4.
- IDLE_CYC, 96000, clk cycles with select high after the last port before the next sweep (2 ms at 48 MHz; must exceed the pad's 1.5 ms 6-button counter reset).
- PW, $clog2(NPORTS) with minimum 1, width of the port index.

Ports:
- clk, in, 1, system clock (all logic on posedge).
- reset_n, in, 1, asynchronous active-low reset.
- joy_in, in, 6, raw active-low pad pins {P9,P6,P4,P3,P2,P1} = {C/Start, B/A, R, L, D, U}; asynchronous.
- joy_sel, out, 1, pad select (pin 7) drive.
- joy_port, out, PW, index of the port currently routed onto joy_in.
- joystick, out, 12*NPORTS, port n in bits [12n+11:12n], active-high: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z.
- connected, out, NPORTS, pad-present flag per port.
- six_btn, out, NPORTS, 6-button pad detected per port.
- scan_done, out, 1, one-cycle pulse when a full sweep of all ports completes.

Behaviour:
- Reset (async assert, sync release): joystick=0, connected=0, six_btn=0, joy_sel=1, joy_port=0, scan_done=0, FSM=IDLE, counters=0. Reset mid-sweep discards all partially captured data.
- Input sync: joy_in passes through a 2-FF synchroniser. All samples use the synchronised value, inverted to active-high.
- FSM states: IDLE, SCAN.
  - IDLE: joy_sel=1 and joy_port=0; counts IDLE_CYC cycles, then enters SCAN at phase 0.
  - SCAN: phases p=0..7, each lasting PHASE_CYC cycles; joy_sel = ~p[0] (H,L,H,L,H,L,H,L).
- Sampling: on the last cycle of each phase, from synchronised bits s[5:0]:
  - p0 (H): R,L,D,U,B,C from s[3],s[2],s[1],s[0],s[4],s[5].
  - p1 (L): A=s[4], Start=s[5]; present = raw L and R pins both low (s[3:2] == 2'b11 after inversion).
  - p5 (L): six = raw U,D,L,R all low (s[3:0] == 4'b1111).
  - p6 (H): if six, Z,Y,X,Mode from s[0],s[1],s[2],s[3]; else these bits are forced 0.
  - Phases 2, 3, 4 and 7 are not sampled.
- Capture and publish:
  - Captured values are held in a shadow word.
  - At the end of p7, the shadow word is copied atomically into joystick[port]; connected[port]=present and six_btn[port]=present&six are written in the same cycle.
  - If !present, the port's word and six_btn are written as 0.
- Port advance:
  - After p7, if joy_port < NPORTS-1: joy_port increments, SCAN restarts at p0, joy_sel stays 1.
  - Otherwise: joy_port=0, scan_done pulses for one cycle, FSM returns to IDLE.
- Consistency: the output word of a port changes only on its publish cycle; there are no intermediate or half-updated values.
- Sweep length: NPORTS*8*PHASE_CYC + IDLE_CYC cycles.
- NPORTS=1: joy_port is constant 0.

Test Plan:
- Reset: hold reset_n=0, pins toggling -> all outputs 0, joy_sel=1; after release, first scan_done after 96000 + 2*8*384 = 102144 cycles (±2).
- 3-button model on port 0 (follows joy_sel; no 6-button response), A+Up pressed -> joystick[11:0]=12'h048, connected[0]=1, six_btn[0]=0.
- 6-button model on port 1, Z+Mode+Right pressed -> joystick[23:12]=12'h901, six_btn[1]=1.
- Port 0 pins floating high -> connected[0]=0, joystick[11:0]=0, even with pins changing mid-scan.
- Button released mid-sweep, after p0 of its port -> old word holds until that port's next publish; no partial update; release seen on the following sweep.
- reset_n asserted during p4 of port 1 -> outputs 0 immediately; next publish only after a full IDLE period; NPORTS=4 sweep shows joy_port sequence 0,1,2,3,0.
